// File: rtl/updn_sweep_ctrl_if.sv
// Sweep controller <-> counter/host bundle.
// master: host + counter side, slave: the sweep controller.
interface updn_sweep_ctrl_if #(
    parameter int unsigned W  = 5,
    parameter int unsigned NW = 4
);
    logic          START;
    logic          ABORT;
    logic [W-1:0]  LO;
    logic [W-1:0]  HI;
    logic [NW-1:0] NSWEEP;
    logic [W-1:0]  Q;
    logic          P_C;
    logic          U_D;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    modport master (
        output START, ABORT, LO, HI, NSWEEP, Q,
        input  P_C, U_D, BUSY, DONE, ERR
    );

    modport slave (
        input  START, ABORT, LO, HI, NSWEEP, Q,
        output P_C, U_D, BUSY, DONE, ERR
    );
endinterface

// File: rtl/updn_sweep_ctrl.sv
// Up/down counter sequencer: N triangle sweeps LO->HI->LO on Q.
// Ports: CLK, RST (async, active-low), bus (slave modport):
//   in  START ABORT LO HI NSWEEP Q ; out P_C U_D BUSY DONE ERR.
// Optional SWEEP_DWELL_EN: DWELL-cycle hold at each turnaround.
module updn_sweep_ctrl #(
    parameter int unsigned W  = 5,
    parameter int unsigned NW = 4
`ifdef SWEEP_DWELL_EN
    ,
    parameter int unsigned DWELL = 3
`endif
) (
    input logic               CLK,
    input logic               RST,
    updn_sweep_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_UP,
        S_DOWN,
        S_DONE,
        S_DWELL
    } state_t;

    localparam logic [NW-1:0] ONE_N = NW'(1);

    state_t        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] nsw_q, nsw_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic          err_q, err_d;
    logic [NW-1:0] cnt_inc;

    logic pc, ud, busy, done;

`ifdef SWEEP_DWELL_EN
    localparam int unsigned DCW =
        (DWELL > 1) ? $clog2(DWELL) : 1;
    logic [DCW-1:0] dwl_cnt_q, dwl_cnt_d;
    // 1 = dwelling at HI (came from UP), 0 = at LO
    logic           dwl_up_q, dwl_up_d;
`endif

    assign cnt_inc = cnt_q + ONE_N;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nsw_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
`ifdef SWEEP_DWELL_EN
            dwl_cnt_q <= '0;
            dwl_up_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nsw_q   <= nsw_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
`ifdef SWEEP_DWELL_EN
            dwl_cnt_q <= dwl_cnt_d;
            dwl_up_q  <= dwl_up_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nsw_d   = nsw_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = 1'b0;
`ifdef SWEEP_DWELL_EN
        dwl_cnt_d = dwl_cnt_q;
        dwl_up_d  = dwl_up_q;
`endif
        if (bus.ABORT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        if (bus.LO >= bus.HI) begin
                            err_d = 1'b1;
                        end else begin
                            lo_d  = bus.LO;
                            hi_d  = bus.HI;
                            nsw_d = bus.NSWEEP;
                            cnt_d = '0;
                            if (bus.NSWEEP == '0)
                                state_d = S_DONE;
                            else
                                state_d = S_SEEK;
                        end
                    end
                end
                S_SEEK: begin
                    if (bus.Q == lo_q)
                        state_d = S_UP;
                end
                S_UP: begin
                    // >= also turns around a Q pushed above HI
                    if (bus.Q >= hi_q) begin
`ifdef SWEEP_DWELL_EN
                        state_d   = S_DWELL;
                        dwl_up_d  = 1'b1;
                        dwl_cnt_d = '0;
`else
                        state_d = S_DOWN;
`endif
                    end
                end
                S_DOWN: begin
                    if (bus.Q <= lo_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == nsw_q) begin
                            state_d = S_DONE;
                        end else begin
`ifdef SWEEP_DWELL_EN
                            state_d   = S_DWELL;
                            dwl_up_d  = 1'b0;
                            dwl_cnt_d = '0;
`else
                            state_d = S_UP;
`endif
                        end
                    end
                end
`ifdef SWEEP_DWELL_EN
                S_DWELL: begin
                    if (dwl_cnt_q == DCW'(DWELL - 1)) begin
                        if (dwl_up_q)
                            state_d = S_DOWN;
                        else
                            state_d = S_UP;
                    end else begin
                        dwl_cnt_d = dwl_cnt_q + DCW'(1);
                    end
                end
`endif
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on state and Q, never on START/ABORT.
    always_comb begin
        pc   = 1'b0;
        ud   = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pc = 1'b0;
            end
            S_SEEK: begin
                busy = 1'b1;
                if (bus.Q < lo_q) begin
                    pc = 1'b1;
                    ud = 1'b1;
                end else if (bus.Q > lo_q) begin
                    pc = 1'b1;
                end
            end
            S_UP: begin
                busy = 1'b1;
                ud   = 1'b1;
                pc   = (bus.Q < hi_q);
            end
            S_DOWN: begin
                busy = 1'b1;
                pc   = (bus.Q > lo_q);
            end
`ifdef SWEEP_DWELL_EN
            S_DWELL: begin
                busy = 1'b1;
                ud   = dwl_up_q;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                pc = 1'b0;
            end
        endcase
    end

    assign bus.P_C  = pc;
    assign bus.U_D  = ud;
    assign bus.BUSY = busy;
    assign bus.DONE = done;
    assign bus.ERR  = err_q;
endmodule
